// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
package wide_add_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit adder with carry in/out and signed overflow (carry into bit 15 xor carry out).
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        overflow
);

    logic [15:0] low;
    logic [1:0]  high;

    // Split at bit 15 so the carry into the sign bit is visible for overflow.
    assign low      = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'b0, cin};
    assign high     = {1'b0, a[15]} + {1'b0, b[15]} + {1'b0, low[15]};
    assign sum      = {high[0], low[14:0]};
    assign cout     = high[1];
    assign overflow = low[15] ^ high[1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-word add/subtract sequencer: reuses one 16-bit adder, one word per clock, LSW first.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [WORD_W*WORDS-1:0]   req_a,
    input  logic [WORD_W*WORDS-1:0]   req_b,
    input  logic                      req_cin,
    input  logic                      req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WORD_W*WORDS-1:0]   rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_overflow,
    output logic                      busy
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [W-1:0]       result;
    logic               cout_q;
    logic               ovf_q;
    logic [WORD_W-1:0]  word_a;
    logic [WORD_W-1:0]  word_b;
    logic [WORD_W-1:0]  word_sum;
    logic               word_cout;
    logic               word_ovf;
    logic               last_word;

    assign word_a    = op_a[int'(idx)*WORD_W +: WORD_W];
    assign word_b    = op_b[int'(idx)*WORD_W +: WORD_W];
    assign last_word = (idx == IDX_W'(WORDS - 1));

    adder_16bit u_adder (
        .a        (word_a),
        .b        (word_b),
        .cin      (carry),
        .sum      (word_sum),
        .cout     (word_cout),
        .overflow (word_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) next_state = RUN;
            end
            RUN: begin
                if (last_word) next_state = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is folded into the latch: B is inverted and the +1 enters as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_a  <= req_a;
                        op_b  <= req_sub ? ~req_b : req_b;
                        carry <= req_sub ? 1'b1 : req_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result[int'(idx)*WORD_W +: WORD_W] <= word_sum;
                    carry <= word_cout;
                    if (last_word) begin
                        idx    <= '0;
                        cout_q <= word_cout;
                        ovf_q  <= word_ovf;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum      = result;
    assign rsp_cout     = cout_q;
    assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer with WORDS=4.
module tb_wide_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic        req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_overflow;
    logic        busy;

    int checks;
    int passes;

    wide_add_sequencer #(.WORDS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sum      (rsp_sum),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, scramble the inputs after acceptance, and count edges to rsp_valid.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output int lat);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = '1;
        req_b     = 64'h1234_5678_9ABC_DEF0;
        req_cin   = ~cin;
        req_sub   = ~sub;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL reset_flags: got ready/valid/busy=%b expected 100",
                     {req_ready, rsp_valid, busy});
        end else passes++;
        checks++;
        if ({rsp_sum, rsp_cout, rsp_overflow} !== 66'h0) begin
            $display("[TB] FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected all zero",
                     rsp_sum, rsp_cout, rsp_overflow);
        end else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_add_vectors();
        logic [63:0] ta [5];
        logic [63:0] tb [5];
        logic        tc [5];
        logic [63:0] es [5];
        logic        ec [5];
        logic        eo [5];
        int          lat;
        ta = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        tb = '{64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000};
        tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{64'h0000_0000_0001_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE,
               64'h8000_0000_0000_0000, 64'h0};
        ec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], tc[i], 1'b0, lat);
            checks++;
            if (lat !== 4) begin
                $display("[TB] FAIL add%0d_latency: got %0d cycles expected 4", i, lat);
            end else passes++;
            checks++;
            if (rsp_sum !== es[i]) begin
                $display("[TB] FAIL add%0d_sum: got %h expected %h", i, rsp_sum, es[i]);
            end else passes++;
            checks++;
            if ({rsp_cout, rsp_overflow} !== {ec[i], eo[i]}) begin
                $display("[TB] FAIL add%0d_flags: got cout/ovf=%b%b expected %b%b",
                         i, rsp_cout, rsp_overflow, ec[i], eo[i]);
            end else passes++;
            release_rsp();
        end
    endtask

    task automatic test_subtract();
        logic [63:0] ta [2];
        logic [63:0] tb [2];
        logic [63:0] es [2];
        logic        ec [2];
        int          lat;
        ta = '{64'h0, 64'h5};
        tb = '{64'h1, 64'h3};
        es = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
        ec = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], 1'b0, 1'b1, lat);
            checks++;
            if (lat !== 4) begin
                $display("[TB] FAIL sub%0d_latency: got %0d cycles expected 4", i, lat);
            end else passes++;
            checks++;
            if (rsp_sum !== es[i]) begin
                $display("[TB] FAIL sub%0d_sum: got %h expected %h", i, rsp_sum, es[i]);
            end else passes++;
            checks++;
            if ({rsp_cout, rsp_overflow} !== {ec[i], 1'b0}) begin
                $display("[TB] FAIL sub%0d_flags: got cout/ovf=%b%b expected %b0",
                         i, rsp_cout, rsp_overflow, ec[i]);
            end else passes++;
            release_rsp();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        @(negedge clk);
        req_a     = 64'h1;
        req_b     = 64'h2;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_a = 64'd10;
        req_b = 64'd20;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            $display("[TB] FAIL b2b_first_latency: got %0d cycles expected 4", lat);
        end else passes++;
        // Backpressure: ten cycles with rsp_ready low while a second request waits.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_sum !== 64'd3 ||
                rsp_cout !== 1'b0 || rsp_overflow !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            $display("[TB] FAIL backpressure_hold: %0d unstable cycles, last sum=%h valid=%b ready=%b expected sum=3 valid=1 ready=0",
                     bad, rsp_sum, rsp_valid, req_ready);
        end else passes++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL b2b_handshake_idle: got ready/valid/busy=%b expected 100",
                     {req_ready, rsp_valid, busy});
        end else passes++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
            $display("[TB] FAIL b2b_second_accept: got ready/busy=%b expected 01", {req_ready, busy});
        end else passes++;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || rsp_sum !== 64'd30) begin
            $display("[TB] FAIL b2b_second_result: got sum=%h after %0d cycles expected 1e after 4",
                     rsp_sum, lat);
        end else passes++;
        release_rsp();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        @(negedge clk);
        req_a     = 64'h0000_0000_0000_FFFF;
        req_b     = 64'h1;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100 ||
            {rsp_sum, rsp_cout, rsp_overflow} !== 66'h0) begin
            $display("[TB] FAIL midrun_reset: got ready/valid/busy=%b sum=%h cout=%b ovf=%b expected 100 and zeros",
                     {req_ready, rsp_valid, busy}, rsp_sum, rsp_cout, rsp_overflow);
        end else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            $display("[TB] FAIL midrun_no_valid: rsp_valid high %0d cycles expected 0", seen);
        end else passes++;
        issue(64'h5, 64'h3, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 4 || rsp_sum !== 64'h2 || rsp_cout !== 1'b1 || rsp_overflow !== 1'b0) begin
            $display("[TB] FAIL post_reset_op: got sum=%h cout=%b ovf=%b lat=%0d expected 2/1/0 lat=4",
                     rsp_sum, rsp_cout, rsp_overflow, lat);
        end else passes++;
        release_rsp();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_add_vectors();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word add/subtract sequencer that time-shares one `adder_16bit` instance to compute WORDS×16-bit results, least-significant word first, one word per clock, chaining carry between words. It sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel). It is the team's controller for reusing the 16-bit adder datapath on wide operands without instantiating a wide carry chain.

## Interface
Parameters:
- `WORDS`, 4: number of 16-bit words per operand. Legal range is 2..16. Operand width is W = 16·WORDS.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_a`  in  W  operand A, unsigned or two's complement.
- `req_b`  in  W  operand B.
- `req_cin`  in  1  carry-in to word 0. Ignored when `req_sub`=1.
- `req_sub`  in  1  0 = A+B+cin; 1 = A−B, computed as A+~B+1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_sum`  out  W  result.
- `rsp_cout`  out  1  carry out of the top word. In subtract mode, 1 means no borrow.
- `rsp_overflow`  out  1  signed overflow of the full W-bit operation.
- `busy`  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`:
    - latch A;
    - latch B, or ~B when `req_sub`=1;
    - latch the carry register as `req_sub` ? 1 : `req_cin`;
    - set word index to 0;
    - move to RUN.
- **RUN**
  - `req_ready`=0.
  - Adder inputs: `a` = A word[idx], `b` = B' word[idx], `cin` = carry register.
  - Each edge:
    - sum word[idx] is written into the result register;
    - the carry register takes the adder's `cout`;
    - idx increments.
  - When idx = WORDS−1 on that edge:
    - `rsp_cout` is set to the adder's `cout`;
    - `rsp_overflow` is set to the adder's `overflow`, which is defined as carry into bit 15 XOR carry out of bit 15;
    - the FSM moves to DONE.
- **DONE**
  - `rsp_valid`=1. `rsp_sum`, `rsp_cout` and `rsp_overflow` are stable.
  - On `rsp_ready`=1, move to IDLE.
  - While `rsp_ready`=0, hold all outputs indefinitely.
- **Width rules**
  - The index counter is $clog2(WORDS) bits wide.
  - Carry into word i+1 is exactly the `cout` of word i.
  - There is no wrap-around: the result is modulo 2^W, and the carry-out reports the excess.
- **Boundary conditions**
  - A new request arriving in RUN or DONE is not accepted. The requester must hold `req_valid`.
  - The latched operands are not affected by `req_*` changes after acceptance.
  - `rsp_ready` asserted outside DONE has no effect.
  - Reset assertion mid-RUN or mid-DONE aborts the operation immediately: the result is discarded and no `rsp_valid` pulse occurs.

## Timing
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `busy`=0;
  - `rsp_sum`=0, `rsp_cout`=0, `rsp_overflow`=0;
  - idx=0, carry register=0.
- Latency: with acceptance at edge k, `rsp_valid` rises after edge k+WORDS. That is WORDS cycles.
- Throughput:
  - the DONE→IDLE handshake takes one edge;
  - the next acceptance happens at the edge after that at the earliest;
  - minimum period is WORDS+2 cycles per operation.
- `req_ready` and `rsp_valid` are registered state decodes. Neither depends combinationally on `req_valid` or `rsp_ready`.
- `busy` = (state ≠ IDLE).

## Structure
- Shared package `wide_add_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant `WORD_W` = 16.
- One sub-module: the existing `adder_16bit` (ports `a`, `b`, `cin`, `sum`, `cout`, `overflow`), instantiated once and driven combinationally from the word-select mux.
- The top level contains:
  - the FSM;
  - the index counter;
  - the carry register;
  - the operand registers;
  - the word-select muxes;
  - the result register.

## Test plan
All scenarios use WORDS=4.
- **Carry ripple:** A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → sum 0x0000_0000_0001_0000, cout=0, ovf=0. `rsp_valid` appears exactly 4 cycles after acceptance.
- **Full ripple with carry-in:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum 0, cout=1, ovf=0. Also A=B=0xFFFF_FFFF_FFFF_FFFF, cin=0 → sum 0xFFFF_FFFF_FFFF_FFFE, cout=1, ovf=0.
- **Signed overflow:** A=0x7FFF_FFFF_FFFF_FFFF, B=1 → sum 0x8000_0000_0000_0000, cout=0, ovf=1. A=B=0x8000_0000_0000_0000 → sum 0, cout=1, ovf=1.
- **Subtract:** A=0, B=1, sub=1 → sum 0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), ovf=0. A=5, B=3, sub=1 → sum 2, cout=1.
- **Backpressure and back-to-back:**
  - hold `rsp_ready`=0 for 10 cycles → outputs are stable and `req_ready` stays 0;
  - with `req_valid` held high for two requests, the second is accepted exactly 1 edge after the first response handshake.
- **Reset mid-operation:**
  - pulse `rst_n` low 2 cycles after acceptance → all outputs return to their reset values asynchronously, and `rsp_valid` never asserts;
  - a new request after reset completes correctly.
